// File: rtl/video_pkg.sv
// Shared video definitions: receiver FSM state encoding and the pixel/line
// counter width, common to video_axis_rx and video_tpg.
package video_pkg;

    localparam int unsigned CNTW = 13;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        RESYNC   = 2'd2
    } rx_state_t;

endpackage

// File: rtl/video_rx_csum.sv
// Frame checksum accumulator: 32-bit wrapping sum of zero-extended pixel data,
// restarted by the SOF beat and latched out on the frame's final EOL beat.
module video_rx_csum
    import video_pkg::*;
#(
    parameter int DATAW = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             beat,
    input  logic             fin,
    input  logic [DATAW-1:0] data,
    output logic [31:0]      csum
);

    logic [31:0] acc;
    logic [31:0] data_ext;
    logic [31:0] acc_sum;

    assign data_ext = 32'(data);
    assign acc_sum  = acc + data_ext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc  <= '0;
            csum <= '0;
        end else begin
            if (sof) begin
                acc <= data_ext;
            end else if (beat) begin
                acc <= acc_sum;
            end
            // the closing beat never coincides with SOF since SCRH >= 2
            if (fin) begin
                csum <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/video_axis_rx.sv
// AXI4-Stream video receiver: frame/line geometry checking with error pulses,
// frame and error counters. Optional frame checksum under VIDEO_AXIS_RX_CSUM_EN.
module video_axis_rx
    import video_pkg::*;
#(
    parameter int DATAW = 24,
    parameter int SCRW  = 1920,
    parameter int SCRH  = 1080
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DATAW-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      err_cnt,
    output logic             err_sof_early,
    output logic             err_eol_early,
    output logic             err_eol_late,
    output logic [12:0]      last_width,
    output logic [31:0]      frame_csum
);

    localparam logic [CNTW-1:0] X_FULL = CNTW'(SCRW);
    localparam logic [CNTW-1:0] Y_LAST = CNTW'(SCRH - 1);

    rx_state_t       state;
    logic [CNTW-1:0] x;
    logic [CNTW-1:0] y;

    logic            accept;
    logic            start;
    logic            eol;
    logic            e_sof;
    logic            e_early;
    logic            e_late;
    logic            to_resync;
    logic            last_line;
    logic [CNTW-1:0] x_nxt;
    logic [CNTW-1:0] width;
    logic [CNTW-1:0] y_cur;
    logic [1:0]      n_err;
    logic [16:0]     err_sum;

    assign accept = s_axis_tvalid & s_axis_tready;
    // saturate so an endless over-long line in RESYNC cannot wrap the count
    assign x_nxt  = (&x) ? x : x + 1'b1;

    always_comb begin
        start     = 1'b0;
        eol       = 1'b0;
        e_sof     = 1'b0;
        e_early   = 1'b0;
        e_late    = 1'b0;
        to_resync = 1'b0;
        if (accept) begin
            case (state)
                WAIT_SOF: begin
                    if (s_axis_tuser) begin
                        start = 1'b1;
                        if (s_axis_tlast) begin
                            eol     = 1'b1;
                            e_early = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (s_axis_tuser) begin
                        e_sof = 1'b1;
                        start = 1'b1;
                        if (s_axis_tlast) begin
                            eol     = 1'b1;
                            e_early = 1'b1;
                        end
                    end else if (s_axis_tlast) begin
                        eol     = 1'b1;
                        e_early = (x_nxt < X_FULL);
                    end else if (x_nxt == X_FULL) begin
                        e_late    = 1'b1;
                        to_resync = 1'b1;
                    end
                end
                RESYNC: begin
                    eol = s_axis_tlast;
                end
                default: ;
            endcase
        end
        width     = start ? CNTW'(1) : x_nxt;
        y_cur     = start ? '0 : y;
        last_line = (y_cur == Y_LAST);
        n_err     = 2'(e_sof) + 2'(e_early) + 2'(e_late);
        err_sum   = {1'b0, err_cnt} + 17'(n_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= WAIT_SOF;
            x             <= '0;
            y             <= '0;
            s_axis_tready <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
            err_sof_early <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
            last_width    <= '0;
        end else begin
            s_axis_tready <= en;
            frame_done    <= 1'b0;
            err_sof_early <= e_sof;
            err_eol_early <= e_early;
            err_eol_late  <= e_late;
            err_cnt       <= err_sum[16] ? '1 : err_sum[15:0];

            if (start) begin
                x     <= CNTW'(1);
                y     <= '0;
                state <= ACTIVE;
            end else if (accept && state != WAIT_SOF) begin
                x <= x_nxt;
            end
            if (to_resync) begin
                state <= RESYNC;
            end
            // line end overrides the SOF restart so a tuser+tlast beat closes line 0
            if (eol) begin
                last_width <= width;
                x          <= '0;
                if (last_line) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                    state      <= WAIT_SOF;
                end else begin
                    y     <= y_cur + 1'b1;
                    state <= ACTIVE;
                end
            end
        end
    end

`ifdef VIDEO_AXIS_RX_CSUM_EN
    video_rx_csum #(
        .DATAW(DATAW)
    ) u_csum (
        .clk  (clk),
        .rst  (rst),
        .sof  (start),
        .beat (accept && state != WAIT_SOF),
        .fin  (eol && last_line),
        .data (s_axis_tdata),
        .csum (frame_csum)
    );
`else
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;
    assign frame_csum   = '0;
`endif

endmodule

// File: tb/tb_video_axis_rx.sv
// Scoreboard bench for video_axis_rx at SCRW=8, SCRH=4: expected pulse events
// are queued by the stimulus and checked by an independent output monitor.
module tb_video_axis_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tuser;
    logic        s_axis_tlast;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        err_sof_early;
    logic        err_eol_early;
    logic        err_eol_late;
    logic [12:0] last_width;
    logic [31:0] frame_csum;

    video_axis_rx #(
        .DATAW(24),
        .SCRW (8),
        .SCRH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .err_sof_early (err_sof_early),
        .err_eol_early (err_eol_early),
        .err_eol_late  (err_eol_late),
        .last_width    (last_width),
        .frame_csum    (frame_csum)
    );

    always #5 clk = ~clk;

    // pulse vector order: {frame_done, err_sof_early, err_eol_early, err_eol_late}
    typedef struct {
        logic [3:0]  pulses;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
        logic [12:0] lw;
        logic [31:0] csum;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic logic [31:0] cs(input logic [31:0] v);
`ifdef VIDEO_AXIS_RX_CSUM_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] p, input int fc, input int ec, input int lw, input logic [31:0] c);
        exp_t e;
        e.pulses = p;
        e.fcnt   = 16'(fc);
        e.ecnt   = 16'(ec);
        e.lw     = 13'(lw);
        e.csum   = cs(c);
        exp_q.push_back(e);
    endtask

    logic [3:0] mon_pulses;
    exp_t       mon_e;

    always @(posedge clk) begin
        #1;
        mon_pulses = {frame_done, err_sof_early, err_eol_early, err_eol_late};
        if (mon_pulses != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(mon_pulses), 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_pulses", 64'(mon_pulses), 64'(mon_e.pulses));
                check("event_frame_cnt", 64'(frame_cnt), 64'(mon_e.fcnt));
                check("event_err_cnt", 64'(err_cnt), 64'(mon_e.ecnt));
                check("event_last_width", 64'(last_width), 64'(mon_e.lw));
                check("event_frame_csum", 64'(frame_csum), 64'(mon_e.csum));
            end
        end
    end

    // called at a negedge; tready seen now is what the next posedge samples
    task automatic beat(input logic [23:0] d, input logic user, input logic last);
        int unsigned waits;
        s_axis_tdata  = d;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        waits = 0;
        while (!s_axis_tready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) check("tready_timeout", 64'(s_axis_tready), 64'h1);
        @(negedge clk);
    endtask

    task automatic send_line(input int n, input logic sof, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            beat(24'(base + i * step), sof && (i == 0), i == n - 1);
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        en = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tready", 64'(s_axis_tready), 64'h0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        check("rst_err_cnt", 64'(err_cnt), 64'h0);
        check("rst_last_width", 64'(last_width), 64'h0);
        check("rst_frame_csum", 64'(frame_csum), 64'h0);
        rst = 1'b1;
        idle(2);
        check("tready_after_rst", 64'(s_axis_tready), 64'h1);

        // clean frame, data 0..31
        push(4'b1000, 1, 0, 8, 32'd496);
        for (int l = 0; l < 4; l++) send_line(8, l == 0, l * 8, 1);
        idle(2);

        // early EOL on beat 5 of line 1
        push(4'b0010, 1, 1, 5, 32'd496);
        push(4'b1000, 2, 1, 8, 32'd29);
        send_line(8, 1'b1, 1, 0);
        send_line(5, 1'b0, 1, 0);
        send_line(8, 1'b0, 1, 0);
        send_line(8, 1'b0, 1, 0);
        idle(2);

        // 10-beat line 2: late error after beat 8, line closes on beat 10
        push(4'b0001, 2, 2, 8, 32'd29);
        send_line(8, 1'b1, 1, 0);
        send_line(8, 1'b0, 1, 0);
        send_line(10, 1'b0, 1, 0);
        check("late_last_width", 64'(last_width), 64'd10);
        push(4'b1000, 3, 2, 8, 32'd34);
        send_line(8, 1'b0, 1, 0);
        idle(2);

        // SOF on beat 3 of line 2 restarts the frame
        send_line(8, 1'b1, 1, 0);
        send_line(8, 1'b0, 1, 0);
        beat(24'd1, 1'b0, 1'b0);
        beat(24'd1, 1'b0, 1'b0);
        push(4'b0100, 3, 3, 8, 32'd34);
        push(4'b1000, 4, 3, 8, 32'd32);
        for (int l = 0; l < 4; l++) send_line(8, l == 0, 1, 0);
        idle(2);

        // SOF+EOL single-beat line 0
        push(4'b0010, 4, 4, 1, 32'd32);
        beat(24'd1, 1'b1, 1'b1);
        push(4'b1000, 5, 4, 8, 32'd25);
        for (int l = 0; l < 3; l++) send_line(8, 1'b0, 1, 0);
        idle(2);

        // enable pause mid-line, then reset mid-frame
        send_line(8, 1'b1, 1, 0);
        for (int i = 0; i < 3; i++) beat(24'd1, 1'b0, 1'b0);
        en = 1'b0;
        idle(1);
        s_axis_tdata  = 24'd1;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("pause_tready", 64'(s_axis_tready), 64'h0);
            @(negedge clk);
        end
        check("pause_frame_cnt", 64'(frame_cnt), 64'd5);
        en = 1'b1;
        for (int i = 3; i < 8; i++) beat(24'd1, 1'b0, i == 7);
        check("pause_no_loss_width", 64'(last_width), 64'd8);
        for (int i = 0; i < 3; i++) beat(24'd1, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        idle(2);
        check("mid_rst_tready", 64'(s_axis_tready), 64'h0);
        check("mid_rst_frame_cnt", 64'(frame_cnt), 64'h0);
        check("mid_rst_err_cnt", 64'(err_cnt), 64'h0);
        check("mid_rst_last_width", 64'(last_width), 64'h0);
        check("mid_rst_frame_csum", 64'(frame_csum), 64'h0);
        rst = 1'b1;
        idle(1);
        send_line(10, 1'b0, 1, 0);
        send_line(8, 1'b0, 1, 0);
        idle(2);
        check("no_sof_ignored_width", 64'(last_width), 64'h0);
        check("no_sof_ignored_err", 64'(err_cnt), 64'h0);
        push(4'b1000, 1, 0, 8, 32'd32);
        for (int l = 0; l < 4; l++) send_line(8, l == 0, 1, 0);
        idle(5);
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
